vproc_vreg_wr_serializer: RTL and testbench

- Write-back stage directly upstream of the vector register file.
- Accepts full-vector-register writes (VREG_W data plus byte enables) from an execution unit through a valid/ready handshake.
- Buffers them in a small FIFO and serializes each one into VREG_W/PORT_W consecutive beats on one PORT_W-wide register-file write port.
- Exports a per-vreg pending mask so upstream hazard logic can stall reads of registers whose writes are still in flight.

---
 rtl/vproc_pkg.sv | 11 +
 rtl/vproc_wr_fifo.sv | 66 ++++++
 rtl/vproc_vreg_wr_serializer.sv | 114 +++++++++++
 tb/tb_vproc_vreg_wr_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared constants for the vector processor slice; helper for elaboration-time checks.
package vproc_pkg;

    localparam int unsigned VREG_ADDR_W = 5;
    localparam int unsigned NUM_VREGS   = 32;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vproc_wr_fifo.sv
// Generic circular-buffer FIFO with per-entry valid bits. It exposes a tag field of every
// valid entry, so a write-back path can track which destinations are still in flight.
module vproc_wr_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 1,
    parameter int unsigned TAG_LSB = 0
) (
    input  logic                            clk_i,
    input  logic                            async_rst_ni,
    input  logic                            push_i,
    input  logic [WIDTH-1:0]                data_i,
    output logic                            full_o,
    input  logic                            pop_i,
    output logic                            empty_o,
    output logic [WIDTH-1:0]                head_o,
    output logic [DEPTH-1:0][TAG_W-1:0]     tag_o,
    output logic [DEPTH-1:0]                tag_vld_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0]            vld_q;
    logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
    logic                        do_push, do_pop;

    // Explicit compare-and-reset, so non-power-of-two depths wrap correctly
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The slot under the write pointer is occupied only when the ring is full
    assign full_o  = vld_q[wr_ptr_q];
    assign empty_o = !vld_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_next(rd_ptr_q);
            end
            if (do_push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_tag
        assign tag_o[i] = mem_q[i][TAG_LSB +: TAG_W];
    end
    assign tag_vld_o = vld_q;

endmodule

// File: rtl/vproc_vreg_wr_serializer.sv
// Buffers whole-vreg writes and drains each as BEATS consecutive port-width beats into the
// register file, while publishing a mask of vregs with writes still in flight.
module vproc_vreg_wr_serializer
    import vproc_pkg::*;
#(
    parameter  int unsigned VREG_W    = 128,
    parameter  int unsigned PORT_W    = 32,
    parameter  int unsigned BUF_DEPTH = 2,
    localparam int unsigned BEATS     = VREG_W / PORT_W,
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 0
) (
    input  logic                          clk_i,
    input  logic                          async_rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [VREG_ADDR_W-1:0]        req_vaddr_i,
    input  logic [VREG_W-1:0]             req_data_i,
    input  logic [VREG_W/8-1:0]           req_be_i,
    output logic [VREG_ADDR_W+BEAT_W-1:0] wr_addr_o,
    output logic [PORT_W-1:0]             wr_data_o,
    output logic [PORT_W/8-1:0]           wr_be_o,
    output logic                          wr_we_o,
    output logic [NUM_VREGS-1:0]          pend_vreg_o,
    output logic                          busy_o
);

    if (VREG_W % PORT_W != 0) begin : g_chk_ratio
        $error("VREG_W must be a multiple of PORT_W");
    end
    if (!is_pow2(BEATS)) begin : g_chk_pow2
        $error("VREG_W/PORT_W must be a power of two");
    end
    if (BUF_DEPTH == 0) begin : g_chk_depth
        $error("BUF_DEPTH must be at least 1");
    end

    typedef struct packed {
        logic [VREG_ADDR_W-1:0] vaddr;
        logic [VREG_W-1:0]      data;
        logic [VREG_W/8-1:0]    be;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t                                 req_entry, head;
    logic [ENTRY_W-1:0]                     head_raw;
    logic                                   full, empty, push, pop, last;
    logic [BUF_DEPTH-1:0][VREG_ADDR_W-1:0]  tags;
    logic [BUF_DEPTH-1:0]                   tag_vld;
    logic [BEATS-1:0][PORT_W-1:0]           data_beats;
    logic [BEATS-1:0][PORT_W/8-1:0]         be_beats;
    logic [PORT_W-1:0]                      beat_data;
    logic [PORT_W/8-1:0]                    beat_be;

    assign req_entry = '{vaddr: req_vaddr_i, data: req_data_i, be: req_be_i};
    assign push      = req_valid_i && !full;
    assign pop       = !empty && last;

    vproc_wr_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (BUF_DEPTH),
        .TAG_W   (VREG_ADDR_W),
        .TAG_LSB (VREG_W + VREG_W / 8)
    ) u_fifo (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .push_i       (push),
        .data_i       (req_entry),
        .full_o       (full),
        .pop_i        (pop),
        .empty_o      (empty),
        .head_o       (head_raw),
        .tag_o        (tags),
        .tag_vld_o    (tag_vld)
    );

    assign head       = entry_t'(head_raw);
    assign data_beats = head.data;
    assign be_beats   = head.be;

    if (BEATS > 1) begin : g_cnt
        logic [BEAT_W-1:0] beat_q;

        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) beat_q <= '0;
            else if (!empty)   beat_q <= last ? '0 : beat_q + 1'b1;
        end

        assign last      = (beat_q == BEAT_W'(BEATS - 1));
        assign wr_addr_o = {head.vaddr, beat_q};
        assign beat_data = data_beats[beat_q];
        assign beat_be   = be_beats[beat_q];
    end else begin : g_single
        assign last      = 1'b1;
        assign wr_addr_o = head.vaddr;
        assign beat_data = data_beats[0];
        assign beat_be   = be_beats[0];
    end

    // Gating on the FIFO valid bits makes the port drop as soon as reset hits
    assign wr_data_o   = beat_data;
    assign wr_be_o     = empty ? '0 : beat_be;
    assign wr_we_o     = |wr_be_o;
    assign req_ready_o = !full;
    assign busy_o      = !empty;

    always_comb begin
        pend_vreg_o = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (tag_vld[i]) pend_vreg_o[tags[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_vproc_vreg_wr_serializer.sv
// Bench: expected register-file beat stream kept as a queue of beats; the default
// 128/32 instance is checked every cycle, a 128/128 instance by directed steps.
module tb_vproc_vreg_wr_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_vaddr = '0;
    logic [127:0] req_data = '0;
    logic [15:0]  req_be = '0;
    logic [6:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic         wr_we;
    logic [31:0]  pend;
    logic         busy;

    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [4:0]   req1_vaddr = '0;
    logic [127:0] req1_data = '0;
    logic [15:0]  req1_be = '0;
    logic [4:0]   wr1_addr;
    logic [127:0] wr1_data;
    logic [15:0]  wr1_be;
    logic         wr1_we;
    logic [31:0]  pend1;
    logic         busy1;

    vproc_vreg_wr_serializer #(.VREG_W(128), .PORT_W(32), .BUF_DEPTH(2)) dut (
        .clk_i(clk), .async_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vaddr_i(req_vaddr),
        .req_data_i(req_data), .req_be_i(req_be),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be), .wr_we_o(wr_we),
        .pend_vreg_o(pend), .busy_o(busy)
    );

    vproc_vreg_wr_serializer #(.VREG_W(128), .PORT_W(128), .BUF_DEPTH(2)) dut1 (
        .clk_i(clk), .async_rst_ni(rst_n),
        .req_valid_i(req1_valid), .req_ready_o(req1_ready), .req_vaddr_i(req1_vaddr),
        .req_data_i(req1_data), .req_be_i(req1_be),
        .wr_addr_o(wr1_addr), .wr_data_o(wr1_data), .wr_be_o(wr1_be), .wr_we_o(wr1_we),
        .pend_vreg_o(pend1), .busy_o(busy1)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    beat_t expq[$];
    int    nvec = 0;
    int    nerr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entries still buffered = beats outstanding rounded up to whole vregs
    function automatic bit model_ready();
        return ((expq.size() + 3) / 4) < 2;
    endfunction

    task automatic check_dut0();
        logic [31:0] p = '0;
        foreach (expq[i]) p[expq[i].addr[6:2]] = 1'b1;
        chk("ready", req_ready, model_ready());
        chk("busy", busy, expq.size() != 0);
        chk("pend", pend, p);
        if (expq.size() != 0) begin
            chk("addr", wr_addr, expq[0].addr);
            chk("data", wr_data, expq[0].data);
            chk("be", wr_be, expq[0].be);
            chk("we", wr_we, |expq[0].be);
        end else begin
            chk("idle_we", wr_we, 1'b0);
            chk("idle_be", wr_be, 4'h0);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        bit           acc = req_valid && model_ready();
        logic [4:0]   va = req_vaddr;
        logic [127:0] d = req_data;
        logic [15:0]  be = req_be;
        @(posedge clk);
        if (expq.size() != 0) void'(expq.pop_front());
        if (acc) begin
            for (int b = 0; b < 4; b++) begin
                beat_t bt;
                bt.addr = {va, 2'(b)};
                bt.data = d[b*32 +: 32];
                bt.be   = be[b*4 +: 4];
                expq.push_back(bt);
            end
        end
        @(negedge clk);
        check_dut0();
    endtask

    task automatic send(input logic [4:0] va, input logic [127:0] d, input logic [15:0] be);
        bit acc = 1'b0;
        int n = 0;
        req_valid = 1'b1;
        req_vaddr = va;
        req_data  = d;
        req_be    = be;
        while (!acc && n < 50) begin
            acc = model_ready();
            step();
            n++;
        end
        chk("send_accepted", acc, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        step();
    endtask

    initial begin
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", wr_we, 1'b0);
        chk("rst_be", wr_be, 4'h0);
        chk("rst_pend", pend, 32'h0);
        chk("rst1_ready", req1_ready, 1'b1);
        chk("rst1_we", wr1_we, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single write to vreg 5, beats D0..D3 at addresses 20..23
        send(5'd5, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 16'hFFFF);
        chk("single_addr0", wr_addr, 7'd20);
        chk("single_pend5", pend[5], 1'b1);
        drain();
        chk("single_pend5_clr", pend[5], 1'b0);

        // sparse enables: only beat 1 writes
        send(5'd3, {$urandom, $urandom, $urandom, $urandom}, 16'h00F0);
        drain();

        // back-pressure with three held requests
        send(5'd1, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        send(5'd2, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        chk("bp_ready_low", req_ready, 1'b0);
        send(5'd3, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        drain();

        // duplicate target keeps the pending bit set
        send(5'd7, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        send(5'd7, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        drain();

        // asynchronous reset during beat 2
        send(5'd12, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        step();
        step();
        chk("mid_beat2_addr", wr_addr, 7'd50);
        rst_n = 1'b0;
        #1;
        chk("arst_we", wr_we, 1'b0);
        chk("arst_pend", pend, 32'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", req_ready, 1'b1);
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // randomized traffic, few distinct vregs to provoke duplicates
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_vaddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            req_be    = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom & $urandom);
            step();
        end
        req_valid = 1'b0;
        drain();

        // single-beat instance: vregs 9 and 10 on consecutive cycles
        begin
            logic [127:0] d9 = {$urandom, $urandom, $urandom, $urandom};
            logic [127:0] d10 = {$urandom, $urandom, $urandom, $urandom};
            req1_valid = 1'b1;
            req1_vaddr = 5'd9;
            req1_data  = d9;
            req1_be    = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            chk("b1_addr9", wr1_addr, 5'd9);
            chk("b1_data9", wr1_data, d9);
            chk("b1_we9", wr1_we, 1'b1);
            chk("b1_pend9", pend1, 32'h0000_0200);
            chk("b1_ready", req1_ready, 1'b1);
            req1_vaddr = 5'd10;
            req1_data  = d10;
            @(posedge clk);
            @(negedge clk);
            chk("b1_addr10", wr1_addr, 5'd10);
            chk("b1_data10", wr1_data, d10);
            chk("b1_we10", wr1_we, 1'b1);
            chk("b1_pend10", pend1, 32'h0000_0400);
            req1_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("b1_idle_we", wr1_we, 1'b0);
            chk("b1_idle_busy", busy1, 1'b0);
            chk("b1_idle_pend", pend1, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
